// File: rtl/synfifo_stream_pkg.sv
// Shared constants and helpers for the SynFifo stream reader.
//   BEAT_CNT_W     : width of the burst beat counter
//   MAX_RD_LATENCY : largest supported FIFO read latency
//   clog2_w()      : ceil(log2(n)), never less than 1, for sizing counters/pointers
package synfifo_stream_pkg;

    localparam int BEAT_CNT_W     = 16;
    localparam int MAX_RD_LATENCY = 3;

    function automatic int clog2_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/synfifo_stream_reader_stream_buf.sv
// stream_buf: small circular buffer that absorbs words landing from the FIFO
// read pipe and presents the oldest one as the stream head.
//   clk, rst    : clock, synchronous active-high reset
//   push        : write push_data at the tail this cycle
//   push_data   : word to store
//   pop         : consumer takes the head (ignored when empty)
//   head_data   : oldest stored word (0 when empty)
//   head_valid  : buffer holds at least one word
//   occ         : number of stored words
module stream_buf
    import synfifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [DATA_WIDTH-1:0]          push_data,
    input  logic                           pop,
    output logic [DATA_WIDTH-1:0]          head_data,
    output logic                           head_valid,
    output logic [clog2_w(DEPTH+1)-1:0]    occ
);

    localparam int PTR_W = clog2_w(DEPTH);
    localparam int OCC_W = clog2_w(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        do_pop   = pop && (occ_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, do_pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // The head slot is never written while occupied, so the head is stable
    // until it is popped.
    assign head_valid = (occ_q != '0);
    assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
    assign occ        = occ_q;

    // The upstream credit check must make overflow impossible.
    assert property (@(posedge clk) disable iff (rst)
        !(push && !do_pop && (occ_q == OCC_W'(DEPTH))))
        else $error("stream_buf overflow");

endmodule

// File: rtl/synfifo_stream_reader.sv
// synfifo_stream_reader: drains a SynFifo into a valid/ready stream.
// Reads are issued only when a buffer slot is guaranteed for the returning
// word, so the FIFO read latency is hidden and 1 word/cycle is sustained.
//   clk, rst    : clock, synchronous active-high reset
//   enable      : allow new reads (in-flight reads always complete)
//   fifo_empty  : SynFifo empty flag
//   fifo_data   : SynFifo read data, valid RD_LATENCY cycles after rdreq
//   fifo_rdreq  : read request to SynFifo
//   out_data    : stream word
//   out_valid   : out_data holds a word
//   out_ready   : consumer accepts the word this cycle
//   out_last    : final beat of a BURST_LEN-beat burst
//   busy        : words buffered or reads in flight
// Handshake: a beat moves on a clk edge where out_valid && out_ready; while
// out_valid is high and out_ready low, out_data/out_valid/out_last hold.
module synfifo_stream_reader
    import synfifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int BURST_LEN  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rdreq,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy
);

    localparam int BUF_DEPTH = RD_LATENCY + 2;
    localparam int OCC_W     = clog2_w(BUF_DEPTH + 1);
    localparam logic [OCC_W:0] CREDIT_MAX = (OCC_W + 1)'(BUF_DEPTH);

    logic [RD_LATENCY-1:0] pipe_q, pipe_d;
    logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [OCC_W-1:0]      occ;
    logic [OCC_W-1:0]      inflight;
    logic [OCC_W:0]        credit_used;
    logic                  xfer;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + OCC_W'(pipe_q[i]);
        end
    end

    // Every word already requested owns a buffer slot; only request when a
    // free slot remains. rst gates the request so nothing is read while the
    // FIFO and this block are being cleared.
    assign credit_used = {1'b0, occ} + {1'b0, inflight};
    assign fifo_rdreq  = !rst && enable && !fifo_empty && (credit_used < CREDIT_MAX);

    // Valid pipe: bit 0 is the request just sampled; the top bit marks the
    // cycle in which fifo_data carries that word.
    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = fifo_rdreq;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    assign xfer     = out_valid && out_ready;
    assign out_last = out_valid && (beat_cnt_q == BEAT_CNT_W'(BURST_LEN - 1));

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (xfer) begin
            beat_cnt_d = out_last ? '0 : beat_cnt_q + BEAT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q     <= '0;
            beat_cnt_q <= '0;
        end else begin
            pipe_q     <= pipe_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    stream_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (pipe_q[RD_LATENCY-1]),
        .push_data  (fifo_data),
        .pop        (xfer),
        .head_data  (out_data),
        .head_valid (out_valid),
        .occ        (occ)
    );

    assign busy = (occ != '0) || (pipe_q != '0);

    assert property (@(posedge clk) (RD_LATENCY >= 1) && (RD_LATENCY <= MAX_RD_LATENCY))
        else $error("RD_LATENCY out of range");

endmodule

// File: tb/tb_synfifo_stream_reader.sv
module tb_synfifo_stream_reader;

    localparam int DW = 8;
    localparam int RL = 1;
    localparam int BL = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rdreq;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] fifo_mem[$];
    int exp_beat     = 0;
    int xfer_cnt     = 0;
    int last_cnt     = 0;
    int rdreq_cnt    = 0;
    int empty_rd_cnt = 0;

    always #5 clk = ~clk;

    synfifo_stream_reader #(
        .DATA_WIDTH (DW),
        .RD_LATENCY (RL),
        .BURST_LEN  (BL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rdreq (fifo_rdreq),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy)
    );

    // SynFifo model with a registered read port (RD_LATENCY = 1).
    always @(posedge clk) begin
        if (fifo_rdreq) begin
            if (fifo_mem.size() != 0) begin
                fifo_data <= fifo_mem.pop_front();
            end
            fifo_empty <= (fifo_mem.size() == 0);
        end
    end

    // Scoreboard: every accepted beat is compared with the oldest expected
    // word and with the bench's own burst position.
    always @(negedge clk) begin : monitor
        logic [DW-1:0] e;
        logic          el;
        if (!rst) begin
            if (fifo_rdreq) begin
                rdreq_cnt++;
                if (fifo_empty) empty_rd_cnt++;
            end
            if (out_valid && out_ready) begin
                xfer_cnt++;
                el = (exp_beat == BL - 1);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra_word: got %0d, expected no word", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        errors++;
                        $display("FAIL sb_data: got %0d, expected %0d", out_data, e);
                    end
                end
                checks++;
                if (out_last !== el) begin
                    errors++;
                    $display("FAIL sb_last: data %0d got out_last %b, expected %b", out_data, out_last, el);
                end
                if (out_last) last_cnt++;
                exp_beat = el ? 0 : exp_beat + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_write(input logic [DW-1:0] v);
        fifo_mem.push_back(v);
        exp_q.push_back(v);
        fifo_empty = 1'b0;
    endtask

    task automatic fifo_flush();
        fifo_mem.delete();
        fifo_empty = 1'b1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        enable    = 1'b0;
        out_ready = 1'b1;
        fifo_flush();
        exp_q.delete();
        exp_beat = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !busy && fifo_mem.size() == 0) break;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; out_ready = 1'b1; xfer_cnt = 0;
        for (int v = 1; v <= 5; v++) fifo_write(DW'(v));
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (fifo_rdreq !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
                out_last !== 1'b0 || out_data !== '0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: rdreq=%b valid=%b busy=%b last=%b data=%0d, expected all 0",
                         c, fifo_rdreq, out_valid, busy, out_last, out_data);
            end
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (fifo_rdreq !== 1'b1) begin
            errors++;
            $display("FAIL first_rdreq: got %b, expected 1", fifo_rdreq);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_valid_early: got %b, expected 0", out_valid);
        end
        wait_drain(50);
        checks++;
        if (xfer_cnt != 5 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_drain: got %0d beats (%0d pending), expected 5 (0)", xfer_cnt, exp_q.size());
        end
    endtask

    task automatic test_streaming();
        int run;
        do_reset();
        xfer_cnt = 0; last_cnt = 0;
        for (int v = 1; v <= 39; v++) fifo_write(DW'(v));
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (fifo_rdreq !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_start: rdreq=%b valid=%b, expected 1/0", fifo_rdreq, out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_fill: valid=%b, expected 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== DW'(1)) begin
            errors++;
            $display("FAIL stream_latency: valid=%b data=%0d, expected 1/1", out_valid, out_data);
        end
        run = 0;
        for (int i = 0; i < 60; i++) begin
            if (!out_valid) break;
            run++;
            @(negedge clk);
        end
        checks++;
        if (run != 39) begin
            errors++;
            $display("FAIL stream_run: got %0d back-to-back beats, expected 39", run);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stream_busy_end: got %b, expected 0", busy);
        end
        checks++;
        if (xfer_cnt != 39 || last_cnt != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_totals: beats=%0d lasts=%0d pending=%0d, expected 39/2/0",
                     xfer_cnt, last_cnt, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] held;
        logic          held_last;
        do_reset();
        xfer_cnt = 0;
        for (int v = 1; v <= 20; v++) fifo_write(DW'(v + 40));
        enable = 1'b1;
        repeat (6) tick();
        out_ready = 1'b0;
        rdreq_cnt = 0;
        @(negedge clk);
        held = out_data;
        held_last = out_last;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== held || out_last !== held_last) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: valid=%b data=%0d last=%b, expected 1/%0d/%b",
                         c, out_valid, out_data, out_last, held, held_last);
            end
            if (c < 9) @(negedge clk);
        end
        checks++;
        if (fifo_rdreq !== 1'b0 || rdreq_cnt != 1) begin
            errors++;
            $display("FAIL bp_credit: rdreq=%b reads_during_stall=%0d, expected 0/1", fifo_rdreq, rdreq_cnt);
        end
        checks++;
        if ((20 - fifo_mem.size()) != xfer_cnt + 3) begin
            errors++;
            $display("FAIL bp_words_taken: got %0d, expected %0d", 20 - fifo_mem.size(), xfer_cnt + 3);
        end
        tick();
        out_ready = 1'b1;
        wait_drain(100);
        checks++;
        if (xfer_cnt != 20 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_totals: beats=%0d pending=%0d, expected 20/0", xfer_cnt, exp_q.size());
        end
    endtask

    task automatic test_empty_boundary();
        do_reset();
        xfer_cnt = 0; rdreq_cnt = 0; empty_rd_cnt = 0;
        enable = 1'b1;
        fifo_write(DW'(100));
        repeat (5) tick();
        fifo_write(DW'(101));
        fifo_write(DW'(102));
        repeat (12) tick();
        checks++;
        if (rdreq_cnt != 3) begin
            errors++;
            $display("FAIL empty_rdreq_count: got %0d, expected 3", rdreq_cnt);
        end
        checks++;
        if (empty_rd_cnt != 0) begin
            errors++;
            $display("FAIL empty_rdreq_while_empty: got %0d, expected 0", empty_rd_cnt);
        end
        checks++;
        if (xfer_cnt != 3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL empty_totals: beats=%0d pending=%0d, expected 3/0", xfer_cnt, exp_q.size());
        end
    endtask

    task automatic test_enable_drop();
        int fifo_left;
        do_reset();
        xfer_cnt = 0; last_cnt = 0;
        for (int v = 1; v <= 10; v++) fifo_write(DW'(v));
        enable = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        checks++;
        if (fifo_rdreq !== 1'b1) begin
            errors++;
            $display("FAIL en_pre_drop_rdreq: got %b, expected 1", fifo_rdreq);
        end
        tick();
        enable = 1'b0;
        rdreq_cnt = 0;
        fifo_left = fifo_mem.size();
        repeat (10) tick();
        checks++;
        if (rdreq_cnt != 0 || fifo_mem.size() != fifo_left) begin
            errors++;
            $display("FAIL en_no_reads: reads=%0d left=%0d, expected 0/%0d", rdreq_cnt, fifo_mem.size(), fifo_left);
        end
        checks++;
        if (busy !== 1'b0 || exp_q.size() != fifo_left || xfer_cnt != 10 - fifo_left) begin
            errors++;
            $display("FAIL en_inflight_delivered: busy=%b pending=%0d beats=%0d, expected 0/%0d/%0d",
                     busy, exp_q.size(), xfer_cnt, fifo_left, 10 - fifo_left);
        end
        for (int v = 11; v <= 20; v++) fifo_write(DW'(v));
        enable = 1'b1;
        wait_drain(100);
        checks++;
        if (xfer_cnt != 20 || last_cnt != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL en_resume: beats=%0d lasts=%0d pending=%0d, expected 20/1/0",
                     xfer_cnt, last_cnt, exp_q.size());
        end
    endtask

    task automatic test_midop_reset();
        do_reset();
        xfer_cnt = 0;
        for (int v = 1; v <= 30; v++) fifo_write(DW'(v));
        enable = 1'b1;
        repeat (7) tick();
        out_ready = 1'b0;
        tick();
        // Two words buffered and one read in flight; reset lands at the next edge.
        rst = 1'b1;
        fifo_flush();
        exp_q.delete();
        exp_beat = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_state: busy=%b valid=%b, expected 1/1", busy, out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 ||
            out_data !== '0 || fifo_rdreq !== 1'b0) begin
            errors++;
            $display("FAIL rst_midop: valid=%b busy=%b last=%b data=%0d rdreq=%b, expected all 0",
                     out_valid, busy, out_last, out_data, fifo_rdreq);
        end
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        xfer_cnt = 0; last_cnt = 0;
        for (int v = 1; v <= 20; v++) fifo_write(DW'(v + 100));
        wait_drain(100);
        checks++;
        if (xfer_cnt != 20 || last_cnt != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rst_after: beats=%0d lasts=%0d pending=%0d, expected 20/1/0",
                     xfer_cnt, last_cnt, exp_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_empty_boundary();
        test_enable_drop();
        test_midop_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/synfifo_stream_reader.md
Name: synfifo_stream_reader

Overview:
Downstream drain stage for SynFifo. Issues rdreq to the FIFO, absorbs the FIFO's registered read latency in a small local buffer, and presents the words as a valid/ready stream. Marks every BURST_LEN-th accepted beat with out_last for framing by the next consumer. Sustains 1 word/cycle when the FIFO is non-empty and out_ready is held high.

Parameters:
DATA_WIDTH, 8, word width; must equal the SynFifo DATA_WIDTH.
RD_LATENCY, 1, cycles from a sampled rdreq to valid fifo_data; legal values 1..3.
BURST_LEN, 16, beats per burst; out_last is asserted on the final beat; legal range 1..65535.
BUF_DEPTH, RD_LATENCY+2, local buffer entries; derived, not overridable.

Ports:
clk  in  1  rising-edge clock shared with SynFifo
rst  in  1  synchronous, active-high reset
enable  in  1  1 = issue reads; 0 = stop new reads (in-flight reads still complete)
fifo_empty  in  1  SynFifo empty flag
fifo_data  in  DATA_WIDTH  SynFifo data_out
fifo_rdreq  out  1  read request to SynFifo
out_data  out  DATA_WIDTH  stream data
out_valid  out  1  out_data holds a word
out_ready  in  1  consumer accepts the word
out_last  out  1  final beat of the current burst
busy  out  1  buffer non-empty or reads in flight

Behaviour:
- Reset (rst high at a clk edge): fifo_rdreq=0, out_valid=0, out_last=0, out_data=0, busy=0. Buffer pointers, in-flight pipe and beat counter clear. Reset mid-operation discards buffered and in-flight words; SynFifo must be reset in the same cycle.
- fifo_rdreq is combinational from registered state only. It is never a function of out_ready.
  - Asserted when: fifo_rdreq = enable && !fifo_empty && (occ + inflight < BUF_DEPTH).
  - occ = buffered words; inflight = number of 1s in the RD_LATENCY-stage valid pipe.
- Read pipe: rdreq sampled at edge t shifts a 1 into the valid pipe. At edge t+RD_LATENCY, fifo_data is written into the buffer tail.
- Credit rule guarantees no buffer overflow. An overflow is an assertion failure, not a dropped word.
- Buffer: circular, BUF_DEPTH entries; occ counter width is clog2(BUF_DEPTH+1).
  - Head drives out_data/out_valid from registers.
  - Push and pop in the same cycle leave occ unchanged.
  - Pointers wrap modulo BUF_DEPTH.
- Handshake: a beat transfers when out_valid && out_ready at the clk edge.
  - While out_valid is high and out_ready is low, out_data, out_valid and out_last hold stable.
  - out_valid never drops without a transfer (except on rst).
- Burst counter: 16-bit beat_cnt, incremented per transfer.
  - out_last = out_valid && (beat_cnt == BURST_LEN-1).
  - On a transfer with out_last, beat_cnt wraps to 0.
  - With BURST_LEN=1, out_last is high on every beat.
  - An idle gap or enable=0 does not reset beat_cnt.
- enable falling: no rdreq from that cycle on; in-flight words still land and drain normally.
- fifo_empty rising while reads are in flight: no effect; only new requests are gated.
- Latency (FIFO non-empty, buffer empty, out_ready=1): rdreq at edge t → out_valid high after edge t+RD_LATENCY.
- Throughput: with out_ready=1 and the FIFO never empty, fifo_rdreq stays high and one beat transfers every cycle.
- busy = (occ != 0) || (inflight != 0).

Decomposition:
- Package synfifo_stream_pkg holds:
  - BEAT_CNT_W = 16
  - clog2-based width helper
  - MAX_RD_LATENCY = 3
- One natural sub-module: stream_buf. It is the BUF_DEPTH circular buffer with push/pop/occ and registered head outputs.
- The top level holds the credit logic, the read-latency pipe and the burst counter.

Test Plan:
1. Reset/idle: rst=1 for 2 cycles with FIFO holding 5 words → fifo_rdreq=0, out_valid=0, busy=0 throughout reset. First rdreq occurs in the cycle after rst falls.
2. Streaming: SynFifo preloaded with 1..39, out_ready=1, RD_LATENCY=1, BURST_LEN=16.
   - Required: out_data 1..39 in order, one per cycle after a 1-cycle fill.
   - out_last on values 16 and 32; busy falls after value 39 transfers.
3. Backpressure: out_ready=0 for 10 cycles mid-stream.
   - Required: rdreq stops once occ+inflight=3; out_data held stable; no word lost or duplicated.
   - On release, the sequence continues contiguously.
4. Empty boundary: FIFO holds 1 word, then 2 words are written 5 cycles later.
   - Required: exactly 3 rdreq pulses; no rdreq while fifo_empty=1; outputs 3 words in order.
5. Enable drop: deassert enable while one read is in flight → that word is still delivered; no further rdreq; beat_cnt preserved. When enable returns, the sequence and out_last alignment continue.
6. Mid-operation reset: assert rst while occ=2 and inflight=1 → next cycle out_valid=0, busy=0, beat_cnt=0. After release, the first burst's out_last lands on beat 16.
